// File: rtl/rvfpm_issue_queue_if.sv
// Core/FPU-facing bundle of the FP issue queue: the instruction offer, flush, and the issue port.
// The master side is the core plus the FPU ready line; the slave side is the queue itself.
interface rvfpm_issue_queue_if #(
    parameter int XLEN       = 32,
    parameter int X_ID_WIDTH = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_instr;
    logic [X_ID_WIDTH-1:0] in_id;
    logic [XLEN-1:0]       in_xreg;
    logic [31:0]           in_mem;
    logic                  flush;
    logic                  fpu_ready;
    logic                  out_enable;
    logic [31:0]           out_instruction;
    logic [X_ID_WIDTH-1:0] out_id;
    logic [XLEN-1:0]       out_xreg;
    logic [31:0]           out_mem;
    logic                  out_bubble;

    modport master (
        output in_valid, in_instr, in_id, in_xreg, in_mem, flush, fpu_ready,
        input  in_ready, out_enable, out_instruction, out_id, out_xreg, out_mem, out_bubble
    );

    modport slave (
        input  in_valid, in_instr, in_id, in_xreg, in_mem, flush, fpu_ready,
        output in_ready, out_enable, out_instruction, out_id, out_xreg, out_mem, out_bubble
    );
endinterface

// File: rtl/rvfpm_issue_queue.sv
// FP issue queue: circular FIFO feeding the FPU, 1-cycle min latency (no bypass), head shown combinationally.
// Backpressure: in_ready = !full even when popping; FPU stalls via fpu_ready, empty queue issues bubbles.
module rvfpm_issue_queue #(
    parameter int          DEPTH        = 4,
    parameter int          XLEN         = 32,
    parameter int          X_ID_WIDTH   = 4,
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
    input  logic                         ck,
    input  logic                         rst,
    rvfpm_issue_queue_if.slave           q,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic [15:0]                  issued_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [31:0]           instr;
        logic [X_ID_WIDTH-1:0] id;
        logic [XLEN-1:0]       xreg;
        logic [31:0]           mem;
    } entry_t;

    entry_t        ram [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign q.in_ready = !full;
    assign q.out_enable = q.fpu_ready;

    // Flush wins over both sides so a squashed offer never lands in storage.
    assign push = q.in_valid && !full && !q.flush;
    assign pop  = q.fpu_ready && !empty && !q.flush;

    always_ff @(posedge ck) begin
        if (push) begin
            ram[wr_ptr] <= '{instr: q.in_instr, id: q.in_id, xreg: q.in_xreg, mem: q.in_mem};
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            issued_cnt <= '0;
        end else if (q.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + PW'(1);
                issued_cnt <= issued_cnt + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Stale storage is masked whenever the queue is empty, including during reset.
    always_comb begin
        head              = ram[rd_ptr];
        q.out_instruction = BUBBLE_INSTR;
        q.out_id          = '0;
        q.out_xreg        = '0;
        q.out_mem         = '0;
        q.out_bubble      = 1'b1;
        if (!empty) begin
            q.out_instruction = head.instr;
            q.out_id          = head.id;
            q.out_xreg        = head.xreg;
            q.out_mem         = head.mem;
            q.out_bubble      = 1'b0;
        end
    end
endmodule
